// File: rtl/mc_pkg.sv
// Shared types and default widths for the multicore run sequencer.
// State codes are visible on the state output, so they are fixed here.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_IMEM = 3'd1,
    S_RX_DMEM = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_DMEM = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam int DEF_CORE_WORD = 12;
  localparam int DEF_DADDR_W   = 12;
  localparam int DEF_IADDR_W   = 8;

endpackage

// File: rtl/mc_done_aggregator.sv
// Sticky per-core completion tracking and the all-enabled-done reduction.
// A done seen in the evaluation cycle itself counts toward completion.
module mc_done_aggregator #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_enable,
  output logic                 all_done
);

  logic [NUM_CORES-1:0] done_seen;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      done_seen <= '0;
    end else begin
      done_seen <= done_seen | core_done;
    end
  end

  assign all_done = &(done_seen | core_done | ~core_enable);

endmodule

// File: rtl/mc_run_sequencer.sv
// Job sequencer for the multicore top: load, execute, transmit, with
// memory port muxing, loop mode, timeout and a saturating cycle counter.
module mc_run_sequencer
  import mc_pkg::*;
#(
  parameter int          NUM_CORES      = 4,
  parameter int          CORE_WORD      = mc_pkg::DEF_CORE_WORD,
  parameter int          DADDR_W        = mc_pkg::DEF_DADDR_W,
  parameter int          IADDR_W        = mc_pkg::DEF_IADDR_W,
  parameter int          IWORD_W        = 8,
  parameter int          CNT_W          = 26,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic                           loop_mode,
  input  logic [NUM_CORES-1:0]           core_enable,
  input  logic                           imem_rx_done,
  input  logic                           dmem_rx_done,
  input  logic                           dmem_tx_done,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic                           rx_byte_valid,
  output logic                           imem_rx_byte_valid,
  output logic                           dmem_rx_byte_valid,
  input  logic [DADDR_W-1:0]             uart_daddr,
  input  logic [NUM_CORES*CORE_WORD-1:0] uart_dwdata,
  input  logic                           uart_dwe,
  input  logic [DADDR_W-1:0]             core_daddr,
  input  logic [NUM_CORES*CORE_WORD-1:0] core_dwdata,
  input  logic                           core_dwe,
  output logic [DADDR_W-1:0]             dmem_addr,
  output logic [NUM_CORES*CORE_WORD-1:0] dmem_wdata,
  output logic                           dmem_we,
  input  logic [IADDR_W-1:0]             uart_iaddr,
  input  logic [IADDR_W-1:0]             core_iaddr,
  output logic [IADDR_W-1:0]             imem_addr,
  output logic                           core_start,
  output logic                           tx_start,
  output logic [2:0]                     state,
  output logic [CNT_W-1:0]               cycle_count,
  output logic                           count_valid,
  output logic                           timeout_err
);

  if (IWORD_W <= 0) begin : g_bad_iword
    $error("IWORD_W must be positive");
  end

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t cur;
  state_t nxt;
  logic   all_done;
  logic   timeout_hit;
  logic   enter_exec;
  logic   leave_exec;

  assign state       = cur;
  assign enter_exec  = (cur == S_RX_DMEM) && (nxt == S_EXEC);
  assign leave_exec  = (cur == S_EXEC) && (nxt != S_EXEC);
  // cycle_count equals the EXEC cycle index until it saturates
  assign timeout_hit = TO_EN && (cycle_count == TO_LIMIT);

  mc_done_aggregator #(
    .NUM_CORES(NUM_CORES)
  ) u_done (
    .clk        (clk),
    .rst        (rst),
    .clear      (enter_exec),
    .core_done  (core_done),
    .core_enable(core_enable),
    .all_done   (all_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:    if (go) nxt = S_RX_IMEM;
      S_RX_IMEM: if (imem_rx_done) nxt = S_RX_DMEM;
      S_RX_DMEM: if (dmem_rx_done) nxt = S_EXEC;
      S_EXEC: begin
        if (all_done) nxt = S_TX_DMEM;
        else if (timeout_hit) nxt = S_ERROR;
      end
      S_TX_DMEM: begin
        if (dmem_tx_done) nxt = loop_mode ? S_RX_DMEM : S_FINISH;
      end
      S_FINISH,
      S_ERROR:   if (go) nxt = S_RX_IMEM;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_addr          = '0;
    dmem_wdata         = '0;
    dmem_we            = 1'b0;
    imem_addr          = '0;
    imem_rx_byte_valid = 1'b0;
    dmem_rx_byte_valid = 1'b0;
    case (cur)
      S_RX_IMEM: begin
        imem_addr          = uart_iaddr;
        imem_rx_byte_valid = rx_byte_valid;
      end
      S_RX_DMEM: begin
        dmem_addr          = uart_daddr;
        dmem_wdata         = uart_dwdata;
        dmem_we            = uart_dwe;
        dmem_rx_byte_valid = rx_byte_valid;
      end
      S_EXEC: begin
        dmem_addr  = core_daddr;
        dmem_wdata = core_dwdata;
        dmem_we    = core_dwe;
        imem_addr  = core_iaddr;
      end
      S_TX_DMEM: begin
        dmem_addr  = uart_daddr;
        dmem_wdata = uart_dwdata;
        dmem_we    = uart_dwe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_start  <= 1'b0;
      tx_start    <= 1'b0;
      cycle_count <= '0;
      count_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      core_start <= enter_exec;
      tx_start   <= (cur == S_EXEC) && (nxt == S_TX_DMEM);
      if (enter_exec) begin
        cycle_count <= '0;
        count_valid <= 1'b0;
      end else if (leave_exec) begin
        count_valid <= 1'b1;
      end else if (cur == S_EXEC && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (cur == S_EXEC && nxt == S_ERROR) begin
        timeout_err <= 1'b1;
      end else if ((cur == S_FINISH || cur == S_ERROR) && go) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_run_sequencer.sv
// Bench for mc_run_sequencer: cycle model compared every cycle plus
// directed scenarios with literal expectations.
module tb_mc_run_sequencer;

  localparam int NC   = 4;
  localparam int CW   = 12;
  localparam int DW   = NC * CW;
  localparam int DA   = 12;
  localparam int IA   = 8;
  localparam int IW   = 8;
  localparam int CN   = 26;
  localparam int TO   = 20;
  localparam int MAXC = (1 << CN) - 1;

  logic          clk = 1'b0;
  logic          rst, go, loop_mode;
  logic [NC-1:0] core_enable, core_done;
  logic          imem_rx_done, dmem_rx_done, dmem_tx_done;
  logic          rx_byte_valid, imem_rx_byte_valid, dmem_rx_byte_valid;
  logic [DA-1:0] uart_daddr, core_daddr, dmem_addr;
  logic [DW-1:0] uart_dwdata, core_dwdata, dmem_wdata;
  logic          uart_dwe, core_dwe, dmem_we;
  logic [IA-1:0] uart_iaddr, core_iaddr, imem_addr;
  logic          core_start, tx_start, count_valid, timeout_err;
  logic [2:0]    state;
  logic [CN-1:0] cycle_count;

  int total  = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  int            m_state = 0;
  int            m_idx   = 0;
  logic [NC-1:0] m_seen  = '0;
  bit            m_cs = 0, m_ts = 0, m_cv = 0, m_te = 0;

  mc_run_sequencer #(
    .NUM_CORES(NC), .CORE_WORD(CW), .DADDR_W(DA), .IADDR_W(IA),
    .IWORD_W(IW), .CNT_W(CN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .loop_mode(loop_mode),
    .core_enable(core_enable), .imem_rx_done(imem_rx_done),
    .dmem_rx_done(dmem_rx_done), .dmem_tx_done(dmem_tx_done),
    .core_done(core_done), .rx_byte_valid(rx_byte_valid),
    .imem_rx_byte_valid(imem_rx_byte_valid),
    .dmem_rx_byte_valid(dmem_rx_byte_valid),
    .uart_daddr(uart_daddr), .uart_dwdata(uart_dwdata),
    .uart_dwe(uart_dwe), .core_daddr(core_daddr),
    .core_dwdata(core_dwdata), .core_dwe(core_dwe),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .uart_iaddr(uart_iaddr), .core_iaddr(core_iaddr),
    .imem_addr(imem_addr), .core_start(core_start),
    .tx_start(tx_start), .state(state), .cycle_count(cycle_count),
    .count_valid(count_valid), .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Spec-level job model: one step per rising edge
  task automatic model_step();
    int            nx;
    logic [NC-1:0] seen_now;
    if (rst) begin
      m_state = 0; m_idx = 0; m_seen = '0;
      m_cs = 0; m_ts = 0; m_cv = 0; m_te = 0;
      return;
    end
    nx = m_state;
    case (m_state)
      0: if (go) nx = 1;
      1: if (imem_rx_done) nx = 2;
      2: if (dmem_rx_done) nx = 3;
      3: begin
        seen_now = m_seen | core_done;
        if ((seen_now | ~core_enable) == {NC{1'b1}}) nx = 4;
        else if (m_idx == TO) nx = 6;
        m_seen = seen_now;
      end
      4: if (dmem_tx_done) nx = loop_mode ? 2 : 5;
      default: if (go) nx = 1;
    endcase
    m_cs = (nx == 3 && m_state != 3);
    m_ts = (nx == 4 && m_state != 4);
    if (m_cs) begin
      m_idx = 0; m_seen = '0; m_cv = 0;
    end else if (m_state == 3 && nx == 3) begin
      m_idx++;
    end
    if (m_state == 3 && nx != 3) m_cv = 1;
    if (nx == 6 && m_state != 6) m_te = 1;
    if ((m_state == 5 || m_state == 6) && go) m_te = 0;
    m_state = nx;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic compare();
    logic [DA-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_we;
    logic [IA-1:0] e_ia;
    bit            uart_side, core_side;
    uart_side = (m_state == 2 || m_state == 4);
    core_side = (m_state == 3);
    e_addr = uart_side ? uart_daddr  : core_side ? core_daddr  : '0;
    e_wd   = uart_side ? uart_dwdata : core_side ? core_dwdata : '0;
    e_we   = uart_side ? uart_dwe    : core_side ? core_dwe    : 1'b0;
    e_ia   = (m_state == 1) ? uart_iaddr : core_side ? core_iaddr : '0;
    check("m_state", 64'(state), 64'(m_state));
    check("m_core_start", 64'(core_start), 64'(m_cs));
    check("m_tx_start", 64'(tx_start), 64'(m_ts));
    check("m_count", 64'(cycle_count),
          64'((m_idx > MAXC) ? MAXC : m_idx));
    check("m_count_valid", 64'(count_valid), 64'(m_cv));
    check("m_timeout_err", 64'(timeout_err), 64'(m_te));
    check("m_dmem_addr", 64'(dmem_addr), 64'(e_addr));
    check("m_dmem_wdata", 64'(dmem_wdata), 64'(e_wd));
    check("m_dmem_we", 64'(dmem_we), 64'(e_we));
    check("m_imem_addr", 64'(imem_addr), 64'(e_ia));
    check("m_imem_rbv", 64'(imem_rx_byte_valid),
          64'(m_state == 1 && rx_byte_valid));
    check("m_dmem_rbv", 64'(dmem_rx_byte_valid),
          64'(m_state == 2 && rx_byte_valid));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) compare();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    uart_daddr    = DA'($urandom);
    core_daddr    = DA'($urandom);
    uart_dwdata   = DW'({$urandom, $urandom});
    core_dwdata   = DW'({$urandom, $urandom});
    uart_dwe      = 1'($urandom_range(0, 1));
    core_dwe      = 1'($urandom_range(0, 1));
    uart_iaddr    = IA'($urandom);
    core_iaddr    = IA'($urandom);
    rx_byte_valid = 1'($urandom_range(0, 1));
  endtask

  // go, imem done, then dmem done five cycles later; ends in EXEC index 0
  task automatic start_run();
    go = 1; tick(); go = 0;
    imem_rx_done = 1; tick(); imem_rx_done = 0;
    repeat (4) tick();
    dmem_rx_done = 1; tick(); dmem_rx_done = 0;
  endtask

  task automatic exec_until(int last, logic [NC-1:0] fin,
                            int mid, logic [NC-1:0] mid_mask);
    for (int k = 0; k <= last; k++) begin
      core_done = (k == last) ? fin : (k == mid) ? mid_mask : '0;
      tick();
    end
    core_done = '0;
  endtask

  initial begin
    rst = 1; go = 0; loop_mode = 0; core_enable = '1; core_done = '0;
    imem_rx_done = 0; dmem_rx_done = 0; dmem_tx_done = 0;
    rx_byte_valid = 0; uart_daddr = '0; core_daddr = '0;
    uart_dwdata = '0; core_dwdata = '0; uart_dwe = 0; core_dwe = 0;
    uart_iaddr = '0; core_iaddr = '0;
    tick();
    chk_on = 1;
    tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    check("rst_cv", 64'(count_valid), 64'd0);
    check("rst_te", 64'(timeout_err), 64'd0);
    check("rst_cs", 64'(core_start), 64'd0);
    rst = 0;
    tick();

    // nominal run, done bits at EXEC+3/+7/+9/+10
    start_run();
    check("nom_exec", 64'(state), 64'd3);
    check("nom_core_start", 64'(core_start), 64'd1);
    for (int k = 0; k <= 10; k++) begin
      core_done = (k == 3) ? 4'b0001 : (k == 7) ? 4'b0010 :
                  (k == 9) ? 4'b0100 : (k == 10) ? 4'b1000 : 4'b0000;
      tick();
    end
    core_done = '0;
    check("nom_tx", 64'(state), 64'd4);
    check("nom_tx_start", 64'(tx_start), 64'd1);
    check("nom_count", 64'(cycle_count), 64'd10);
    check("nom_cv", 64'(count_valid), 64'd1);
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;
    check("nom_finish", 64'(state), 64'd5);

    // masking: only cores 0 and 1 count
    core_enable = 4'b0011;
    start_run();
    exec_until(4, 4'b0011, 2, 4'b1100);
    check("mask_tx", 64'(state), 64'd4);
    check("mask_count", 64'(cycle_count), 64'd4);
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;

    // all cores disabled: one EXEC cycle
    core_enable = 4'b0000;
    start_run();
    exec_until(0, 4'b0000, -1, 4'b0000);
    check("zero_en_tx", 64'(state), 64'd4);
    check("zero_en_count", 64'(cycle_count), 64'd0);
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;
    core_enable = 4'b1111;

    // timeout at index 20
    start_run();
    exec_until(TO, 4'b0000, -1, 4'b0000);
    check("to_error", 64'(state), 64'd6);
    check("to_err", 64'(timeout_err), 64'd1);
    check("to_count", 64'(cycle_count), 64'd20);
    go = 1; tick(); go = 0;
    check("to_rx_imem", 64'(state), 64'd1);
    check("to_err_clr", 64'(timeout_err), 64'd0);

    // completion in the timeout cycle wins
    start_run();
    exec_until(TO, 4'b1000, 5, 4'b0111);
    check("sim_tx", 64'(state), 64'd4);
    check("sim_err", 64'(timeout_err), 64'd0);
    check("sim_count", 64'(cycle_count), 64'd20);

    // loop mode and mux steering
    loop_mode = 1; uart_dwe = 1; core_dwe = 0; #1;
    check("we_tx_uart", 64'(dmem_we), 64'd1);
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;
    check("loop_rx_dmem", 64'(state), 64'd2);
    rx_byte_valid = 1; uart_dwe = 1; core_dwe = 0; #1;
    check("rbv_dmem", 64'(dmem_rx_byte_valid), 64'd1);
    check("rbv_imem_off", 64'(imem_rx_byte_valid), 64'd0);
    check("we_rx_uart", 64'(dmem_we), 64'd1);
    dmem_rx_done = 1; tick(); dmem_rx_done = 0;
    check("loop_exec", 64'(state), 64'd3);
    uart_dwe = 1; core_dwe = 0; #1;
    check("we_exec_core0", 64'(dmem_we), 64'd0);
    core_dwe = 1; #1;
    check("we_exec_core1", 64'(dmem_we), 64'd1);
    exec_until(2, 4'b1111, -1, 4'b0000);
    check("loop2_tx", 64'(state), 64'd4);
    check("loop2_count", 64'(cycle_count), 64'd2);
    loop_mode = 0;
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;
    uart_dwe = 1; core_dwe = 1; #1;
    check("we_finish", 64'(dmem_we), 64'd0);
    go = 1; tick(); go = 0;
    rx_byte_valid = 1; uart_iaddr = 8'h5a; #1;
    check("rbv_imem", 64'(imem_rx_byte_valid), 64'd1);
    check("rbv_dmem_off", 64'(dmem_rx_byte_valid), 64'd0);
    check("imem_addr_uart", 64'(imem_addr), 64'h5a);

    // reset mid-EXEC, then a stray tx done in IDLE
    start_run();
    tick(); tick();
    rst = 1; tick(); rst = 0;
    uart_dwe = 1; core_dwe = 1; #1;
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_count", 64'(cycle_count), 64'd0);
    check("mid_rst_we", 64'(dmem_we), 64'd0);
    check("mid_rst_cv", 64'(count_valid), 64'd0);
    dmem_tx_done = 1; tick(); dmem_tx_done = 0;
    check("stray_idle", 64'(state), 64'd0);
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
